wb_ram_responder: RTL

- Pipelined Wishbone B4 slave with an internal word-addressed RAM.
- Sits on the far end of the memory arbiter's master port (m_wb_*) and answers its requests.
- Used as the simulation and integration target for the arbiter and the fetch/load-store paths.
- Latency and back-pressure are configurable, so initiators can be exercised under stall and multi-cycle acks.

---
 rtl/ecap5_dproc_pkg.sv | 29 ++
 rtl/wb_ram_responder_pipe.sv | 32 +++
 rtl/wb_ram_responder.sv | 81 ++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared Wishbone definitions for the data-processor memory paths.
// The byte-lane merge here is also used by the load-store unit.
package ecap5_dproc_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  // One response slot travelling toward the ack output.
  typedef struct packed {
    logic                 valid;
    logic [WB_DATA_W-1:0] data;
  } resp_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [WB_DATA_W-1:0] apply_sel(
    input logic [WB_DATA_W-1:0] old_word,
    input logic [WB_DATA_W-1:0] new_word,
    input logic [WB_SEL_W-1:0]  sel
  );
    logic [WB_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_ram_responder_pipe.sv
// LATENCY-deep response shift register; the last stage drives the bus ack.
// Synchronous flush drops in-flight responses when the initiator aborts.
module wb_resp_pipe
  import ecap5_dproc_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  resp_t in_i,
  output resp_t out_o
);

  resp_t stage_q [LATENCY];

  // NOTE: non-blocking assignments make every stage take its neighbour's
  // pre-edge value, which is what turns this loop into a shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= '0;
    end else if (flush_i) begin
      for (int s = 0; s < LATENCY; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int s = 1; s < LATENCY; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_ram_responder.sv
// Pipelined Wishbone B4 slave backed by a word-addressed RAM, with
// configurable ack latency, outstanding limit and externally forced stall.
module wb_ram_responder
  import ecap5_dproc_pkg::*;
#(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WB_ADDR_W-1:0] wb_adr_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  input  logic                 wb_we_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic                 wb_stall_o,
  input  logic                 stall_req_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  logic [WB_DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]     outstanding_q;
  logic [IDX_W-1:0]     word_idx;
  logic                 accept;
  logic                 flush;
  resp_t                rd_resp;
  resp_t                ack_resp;
  logic                 unused_adr;

  // Upper address bits alias onto the same words; byte offset is covered by sel.
  assign word_idx   = wb_adr_i[IDX_W+1:2];
  assign unused_adr = ^{wb_adr_i[WB_ADDR_W-1:IDX_W+2], wb_adr_i[1:0]};

  assign wb_stall_o = rst_ni & ((outstanding_q == CNT_W'(MAX_OUTSTANDING)) | stall_req_i);
  assign accept     = rst_ni & wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign flush      = ~wb_cyc_i;

  // NOTE: the RAM has no reset branch; clearing a memory array is not
  // possible on block RAM and its contents must survive a reset anyway.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i) mem[word_idx] <= apply_sel(mem[word_idx], wb_dat_i, wb_sel_i);
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // a field unassigned and implies a latch.
  always_comb begin
    rd_resp       = '0;
    rd_resp.valid = accept;
    if (accept && !wb_we_i) rd_resp.data = mem[word_idx];
  end

  wb_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .in_i    (rd_resp),
    .out_o   (ack_resp)
  );

  assign wb_ack_o = ack_resp.valid;
  assign wb_dat_o = ack_resp.valid ? ack_resp.data : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (flush) begin
      outstanding_q <= '0;
    end else if (accept && !wb_ack_o) begin
      outstanding_q <= outstanding_q + CNT_W'(1);
    end else if (!accept && wb_ack_o) begin
      outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

endmodule
